// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART transmitter between N_REQ byte producers
// Optional packet lock (requester keeps the line until req_last_i) enabled by defining UART_ARB_LOCK_EN.
module uart_tx_arbiter #(
    parameter int N_REQ         = 4,
    parameter int START_TIMEOUT = 15,
    parameter int CNT_W         = 16
) (
    input  logic                 clk_i,
    input  logic                 nreset_i,
    input  logic [N_REQ-1:0]     req_valid_i,
    input  logic [8*N_REQ-1:0]   req_data_i,
    input  logic [N_REQ-1:0]     req_last_i,
    output logic [N_REQ-1:0]     req_ack_o,
    output logic [N_REQ-1:0]     grant_o,
    output logic [7:0]           tx_data_o,
    output logic                 tx_start_o,
    input  logic                 tx_busy_i,
    output logic                 timeout_err_o,
    input  logic                 err_clr_i,
    output logic [CNT_W-1:0]     frames_sent_o
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int TO_W  = $clog2(START_TIMEOUT + 1);

`ifdef UART_ARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t            state_q;
    logic [IDX_W-1:0]  ptr_q;
    logic [IDX_W-1:0]  win_q;
    logic [TO_W-1:0]   to_cnt_q;
    logic              lock_q;
    logic              last_q;

    logic              found_c;
    logic [IDX_W-1:0]  pick_c;
    logic [IDX_W-1:0]  cand_c;
    logic [IDX_W-1:0]  next_c;
    logic [7:0]        data_c;
    logic              last_c;
    logic [N_REQ-1:0]  pick_onehot_c;

    // Index addition modulo N_REQ; the extra bit keeps the sum from overflowing before the wrap.
    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                   input logic [IDX_W:0]   off);
        logic [IDX_W:0] s;
        s = {1'b0, base} + off;
        if (s >= (IDX_W+1)'(N_REQ)) begin
            s = s - (IDX_W+1)'(N_REQ);
        end
        return s[IDX_W-1:0];
    endfunction

    // First valid requester at or after the pointer, searching upward with wrap.
    always_comb begin
        found_c = 1'b0;
        pick_c  = '0;
        cand_c  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand_c = wrap_add(ptr_q, (IDX_W+1)'(i));
            if (!found_c && req_valid_i[cand_c]) begin
                found_c = 1'b1;
                pick_c  = cand_c;
            end
        end
    end

    always_comb begin
        data_c = 8'h00;
        last_c = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_c == IDX_W'(i)) begin
                data_c = req_data_i[8*i +: 8];
                last_c = req_last_i[i];
            end
        end
    end

    assign next_c        = wrap_add(win_q, (IDX_W+1)'(1));
    assign pick_onehot_c = {{(N_REQ-1){1'b0}}, 1'b1} << pick_c;

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            win_q         <= '0;
            to_cnt_q      <= '0;
            lock_q        <= 1'b0;
            last_q        <= 1'b0;
            req_ack_o     <= '0;
            grant_o       <= '0;
            tx_data_o     <= 8'h00;
            tx_start_o    <= 1'b0;
            timeout_err_o <= 1'b0;
            frames_sent_o <= '0;
        end else begin
            req_ack_o  <= '0;
            tx_start_o <= 1'b0;
            // A timeout set later in this block overrides the clear.
            if (err_clr_i) begin
                timeout_err_o <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (lock_q && !req_valid_i[win_q]) begin
                        lock_q  <= 1'b0;
                        grant_o <= '0;
                        ptr_q   <= next_c;
                    end else if (found_c && !tx_busy_i) begin
                        win_q     <= pick_c;
                        grant_o   <= pick_onehot_c;
                        req_ack_o <= pick_onehot_c;
                        tx_data_o <= data_c;
                        last_q    <= last_c;
                        state_q   <= LAUNCH;
                    end
                end

                LAUNCH: begin
                    tx_start_o <= 1'b1;
                    to_cnt_q   <= '0;
                    state_q    <= WAIT_BUSY;
                end

                WAIT_BUSY: begin
                    if (tx_busy_i) begin
                        state_q <= WAIT_DONE;
                    end else if (to_cnt_q == TO_W'(START_TIMEOUT)) begin
                        timeout_err_o <= 1'b1;
                        grant_o       <= '0;
                        ptr_q         <= next_c;
                        lock_q        <= 1'b0;
                        state_q       <= IDLE;
                    end else begin
                        to_cnt_q <= to_cnt_q + TO_W'(1);
                    end
                end

                WAIT_DONE: begin
                    if (!tx_busy_i) begin
                        frames_sent_o <= frames_sent_o + CNT_W'(1);
                        state_q       <= IDLE;
                        // Mid-packet bytes keep the same owner and priority.
                        if (LOCK_EN && !last_q) begin
                            lock_q <= 1'b1;
                            ptr_q  <= win_q;
                        end else begin
                            lock_q  <= 1'b0;
                            grant_o <= '0;
                            ptr_q   <= next_c;
                        end
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int TO = 15;
    localparam int CW = 4;

    logic           clk = 1'b0;
    logic           nreset_i = 1'b0;
    logic [N-1:0]   req_valid_i = '0;
    logic [8*N-1:0] req_data_i = '0;
    logic [N-1:0]   req_last_i = '0;
    logic [N-1:0]   req_ack_o;
    logic [N-1:0]   grant_o;
    logic [7:0]     tx_data_o;
    logic           tx_start_o;
    logic           tx_busy_i = 1'b0;
    logic           timeout_err_o;
    logic           err_clr_i = 1'b0;
    logic [CW-1:0]  frames_sent_o;

    uart_tx_arbiter #(.N_REQ(N), .START_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk_i         (clk),
        .nreset_i      (nreset_i),
        .req_valid_i   (req_valid_i),
        .req_data_i    (req_data_i),
        .req_last_i    (req_last_i),
        .req_ack_o     (req_ack_o),
        .grant_o       (grant_o),
        .tx_data_o     (tx_data_o),
        .tx_start_o    (tx_start_o),
        .tx_busy_i     (tx_busy_i),
        .timeout_err_o (timeout_err_o),
        .err_clr_i     (err_clr_i),
        .frames_sent_o (frames_sent_o)
    );

    always #5 clk = ~clk;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [11:0] exp_q[$];
    logic [8:0] mem[N][32];
    int         head[N];
    int         tail[N];
    bit         busy_en = 1'b1;
    int         busy_len = 10;
    int         busy_cnt = 0;
    bit         pend_start = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic load(input int k, input logic [7:0] d, input bit last);
        mem[k][tail[k]] = {last, d};
        tail[k]++;
    endtask

    task automatic push(input int k, input logic [7:0] d);
        logic [3:0] v;
        v = 4'b0001 << k;
        exp_q.push_back({v, d});
    endtask

    function automatic bit drained();
        bit r;
        r = 1'b1;
        for (int k = 0; k < N; k++) if (head[k] != tail[k]) r = 1'b0;
        return r;
    endfunction

    task automatic wait_idle(input string name);
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!(exp_q.size() == 0 && grant_o == '0 && !tx_busy_i && drained()) && t < 3000);
        if (t >= 3000) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: idle not reached, %0d frames left", name, exp_q.size());
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 nreset_i = 1'b0;
        for (int k = 0; k < N; k++) begin
            head[k] = 0;
            tail[k] = 0;
        end
        exp_q.delete();
        busy_en  = 1'b1;
        busy_len = 10;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 nreset_i = 1'b1;
    endtask

    // Requesters: hold each byte until acked, then present the next one.
    initial begin
        for (int k = 0; k < N; k++) begin
            head[k] = 0;
            tail[k] = 0;
        end
        forever begin
            @(negedge clk);
            for (int k = 0; k < N; k++) begin
                if (nreset_i && req_ack_o[k]) head[k]++;
                if (head[k] < tail[k]) begin
                    req_valid_i[k]         = 1'b1;
                    req_data_i[8*k +: 8]   = mem[k][head[k]][7:0];
                    req_last_i[k]          = mem[k][head[k]][8];
                end else begin
                    req_valid_i[k] = 1'b0;
                end
            end
        end
    end

    // Transmitter model: busy for busy_len cycles after each start.
    initial begin
        forever begin
            @(negedge clk);
            if (!nreset_i) begin
                tx_busy_i = 1'b0;
                busy_cnt  = 0;
            end else if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) tx_busy_i = 1'b0;
            end else if (tx_start_o && busy_en) begin
                tx_busy_i = 1'b1;
                busy_cnt  = busy_len;
            end
        end
    end

    // Monitor: every ack is popped against the scoreboard; the start must follow one cycle later.
    initial begin
        logic [11:0] e;
        forever begin
            @(negedge clk);
            if (!nreset_i) begin
                pend_start = 1'b0;
            end else begin
                if (pend_start) check("start_after_ack", tx_start_o, 1'b1);
                else if (tx_start_o) check("spurious_start", tx_start_o, 1'b0);
                pend_start = |req_ack_o;
                if (|req_ack_o) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_ack", req_ack_o, 4'b0000);
                    end else begin
                        e = exp_q.pop_front();
                        check("ack_vec", req_ack_o, e[11:8]);
                        check("grant_at_ack", grant_o, e[11:8]);
                        check("tx_data", tx_data_o, e[7:0]);
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int k;
        repeat (3) @(negedge clk);
        check("rst_grant", grant_o, 0);
        check("rst_ack", req_ack_o, 0);
        check("rst_start", tx_start_o, 0);
        check("rst_data", tx_data_o, 0);
        check("rst_err", timeout_err_o, 0);
        check("rst_frames", frames_sent_o, 0);
        @(posedge clk);
        #1 nreset_i = 1'b1;

        // Single requester 1
        load(1, 8'hA5, 1'b1);
        push(1, 8'hA5);
        wait_idle("single");
        check("single_frames", frames_sent_o, 1);
        check("single_grant", grant_o, 0);
        check("single_data_hold", tx_data_o, 8'hA5);
        check("single_err", timeout_err_o, 0);

        // All four valid, two bytes each: strict rotation
        do_reset();
        for (int r = 0; r < 2; r++)
            for (int q = 0; q < N; q++) begin
                load(q, 8'h10 * (r + 1) + 8'(q), 1'b1);
                push(q, 8'h10 * (r + 1) + 8'(q));
            end
        wait_idle("rr8");
        check("rr8_frames", frames_sent_o, 8);

        // Transmitter never goes busy
        do_reset();
        busy_en = 1'b0;
        load(0, 8'h30, 1'b1);
        load(1, 8'h31, 1'b1);
        push(0, 8'h30);
        push(1, 8'h31);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!tx_start_o && t < 100);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!timeout_err_o && k < 100);
        check("timeout_latency", k, TO + 1);
        check("timeout_grant", grant_o, 0);
        wait_idle("timeout");
        check("timeout_frames", frames_sent_o, 0);
        check("timeout_sticky", timeout_err_o, 1);
        err_clr_i = 1'b1;
        @(negedge clk);
        err_clr_i = 1'b0;
        check("err_clr", timeout_err_o, 0);

        // Asynchronous reset in WAIT_DONE
        do_reset();
        load(2, 8'hE2, 1'b1);
        push(2, 8'hE2);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!tx_busy_i && t < 100);
        check("busy_seen", tx_busy_i, 1);
        @(negedge clk);
        #2 nreset_i = 1'b0;
        #1;
        check("arst_grant", grant_o, 0);
        check("arst_data", tx_data_o, 0);
        check("arst_start", tx_start_o, 0);
        check("arst_ack", req_ack_o, 0);
        check("arst_frames", frames_sent_o, 0);
        for (int q = 0; q < N; q++) begin
            head[q] = 0;
            tail[q] = 0;
        end
        exp_q.delete();
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 nreset_i = 1'b1;
        load(0, 8'h40, 1'b1);
        load(3, 8'h43, 1'b1);
        push(0, 8'h40);
        push(3, 8'h43);
        wait_idle("post_reset");
        check("post_reset_frames", frames_sent_o, 2);

        // Counter wrap: 17 frames on a 4-bit counter
        do_reset();
        busy_len = 3;
        for (int i = 0; i < 17; i++) begin
            load(3, 8'h60 + 8'(i), 1'b1);
            push(3, 8'h60 + 8'(i));
        end
        wait_idle("wrap");
        check("wrap_frames", frames_sent_o, 1);

        // Packet from requester 2 while requester 3 competes
        do_reset();
        load(2, 8'hC0, 1'b0);
        load(2, 8'hC1, 1'b0);
        load(2, 8'hC2, 1'b1);
        load(3, 8'hD0, 1'b1);
        load(3, 8'hD1, 1'b1);
`ifdef UART_ARB_LOCK_EN
        push(2, 8'hC0);
        push(2, 8'hC1);
        push(2, 8'hC2);
        push(3, 8'hD0);
        push(3, 8'hD1);
`else
        push(2, 8'hC0);
        push(3, 8'hD0);
        push(2, 8'hC1);
        push(3, 8'hD1);
        push(2, 8'hC2);
`endif
        wait_idle("packet");
        check("packet_frames", frames_sent_o, 5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
